tx_rr_sched: RTL

TX_RR_SCHED -- requirements
Module: tx_rr_sched

---
 rtl/tx_sched_pkg.sv | 15 +
 rtl/rr_pick.sv | 31 +++
 rtl/tx_rr_sched.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tx_sched_pkg.sv
// Shared definitions for the TX round-robin frame scheduler: FSM encoding and
// default burst/timeout limits.
package tx_sched_pkg;

  localparam int unsigned DEF_MAX_BURST = 4;
  localparam int unsigned DEF_DONE_TO   = 64;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ARB       = 2'd1,
    S_READ      = 2'd2,
    S_WAIT_DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping modulo N, returned as one-hot plus binary index.
module rr_pick #(
  parameter int unsigned N  = 5,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [IW-1:0] k;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = IW'((32'(ptr) + i) % N);
      if (!valid && req[k]) begin
        valid     = 1'b1;
        idx       = k;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_rr_sched.sv
// Round-robin scheduler granting switch FIFO sources to one frame serializer,
// with full-FIFO priority, bounded bursts and a tx_done watchdog.
module tx_rr_sched
  import tx_sched_pkg::*;
#(
  parameter int unsigned NUM_SW_INST = 5,
  parameter int unsigned MAX_BURST   = DEF_MAX_BURST,
  parameter int unsigned DONE_TO     = DEF_DONE_TO
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SW_INST-1:0]         empty,
  input  logic [NUM_SW_INST-1:0]         full,
  input  logic [NUM_SW_INST-1:0]         sw_busy,
  input  logic [NUM_SW_INST-1:0]         last,
  input  logic                           tx_done,
  output logic [NUM_SW_INST-1:0]         rd_en,
  output logic [NUM_SW_INST-1:0]         grant,
  output logic [$clog2(NUM_SW_INST)-1:0] grant_id,
  output logic                           sched_busy,
  output logic                           timeout_err
);

  localparam int unsigned IW = $clog2(NUM_SW_INST);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam int unsigned WW = (DONE_TO > 1) ? $clog2(DONE_TO) : 1;

  sched_state_e state;

  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic          last_q;

  logic [NUM_SW_INST-1:0] elig;
  logic [NUM_SW_INST-1:0] full_req;
  logic [NUM_SW_INST-1:0] full_oh;
  logic [NUM_SW_INST-1:0] norm_oh;
  logic [NUM_SW_INST-1:0] win_oh;
  logic [IW-1:0]          full_idx;
  logic [IW-1:0]          norm_idx;
  logic [IW-1:0]          win_idx;
  logic                   full_vld;
  logic                   norm_vld;
  logic                   cur_empty;
  logic                   cur_elig;

  assign elig     = ~empty & ~sw_busy;
  assign full_req = elig & full;

  rr_pick #(.N(NUM_SW_INST), .IW(IW)) u_pick_full (
    .req    (full_req),
    .ptr    (rr_ptr),
    .onehot (full_oh),
    .idx    (full_idx),
    .valid  (full_vld)
  );

  rr_pick #(.N(NUM_SW_INST), .IW(IW)) u_pick_norm (
    .req    (elig),
    .ptr    (rr_ptr),
    .onehot (norm_oh),
    .idx    (norm_idx),
    .valid  (norm_vld)
  );

  // A full source always outranks the plain round-robin winner.
  assign win_oh  = full_vld ? full_oh : norm_oh;
  assign win_idx = full_vld ? full_idx : norm_idx;

  assign cur_empty = empty[grant_id];
  assign cur_elig  = elig[grant_id];

  // Gated by the live empty bit and rst so a pulse never hits an empty FIFO
  // or escapes in a reset cycle.
  assign rd_en = (state == S_READ && !rst) ? (grant & ~empty) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      grant       <= '0;
      grant_id    <= '0;
      sched_busy  <= 1'b0;
      timeout_err <= 1'b0;
      rr_ptr      <= IW'(NUM_SW_INST - 1);
      burst_cnt   <= '0;
      wait_cnt    <= '0;
      last_q      <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (|elig) begin
            state      <= S_ARB;
            sched_busy <= 1'b1;
          end
        end
        S_ARB: begin
          if (norm_vld) begin
            grant     <= win_oh;
            grant_id  <= win_idx;
            rr_ptr    <= win_idx;
            burst_cnt <= '0;
            state     <= S_READ;
          end else begin
            grant      <= '0;
            grant_id   <= '0;
            sched_busy <= 1'b0;
            state      <= S_IDLE;
          end
        end
        S_READ: begin
          if (!cur_empty) begin
            last_q   <= last[grant_id];
            wait_cnt <= '0;
            state    <= S_WAIT_DONE;
            if (burst_cnt != BW'(MAX_BURST)) begin
              burst_cnt <= burst_cnt + BW'(1);
            end
          end else begin
            state <= S_ARB;
          end
        end
        S_WAIT_DONE: begin
          // tx_done outranks a timeout landing on the same cycle.
          if (tx_done) begin
            if (!last_q && burst_cnt < BW'(MAX_BURST) && cur_elig) begin
              state <= S_READ;
            end else begin
              state <= S_ARB;
            end
          end else if (wait_cnt == WW'(DONE_TO - 1)) begin
            timeout_err <= 1'b1;
            state       <= S_ARB;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
